// File: rtl/axi_lite_initiator_pkg.sv
// Shared definitions for the native-bus to AXI4-Lite initiator.
// Also intended for reuse by the memory controller that sits on the other side of the bus.
package axi_lite_initiator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_RD_ADDR      = 3'd1,
    ST_RD_DATA      = 3'd2,
    ST_WR_ADDR_DATA = 3'd3,
    ST_WR_RESP      = 3'd4,
    ST_DONE         = 3'd5
  } state_e;

  localparam logic [2:0]  PROT_DATA         = 3'b000;
  localparam logic [2:0]  PROT_INSTR        = 3'b100;
  localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hdeadbeef;

  // Instruction fetches are marked in the top bit of the AXI protection field.
  function automatic logic [2:0] prot_for(input logic instr);
    return instr ? PROT_INSTR : PROT_DATA;
  endfunction

endpackage

// File: rtl/axi_lite_initiator_timer.sv
// Watchdog counter for bus transactions.
// expired_o is high during the cycle whose clock edge brings the count up to
// TIMEOUT_CYCLES. The count saturates there. A value of 0 disables the watchdog.
module bus_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES);
  localparam bit WatchdogOn = (TIMEOUT_CYCLES != 0);

  logic [CntW-1:0] count_q;
  logic [CntW-1:0] count_d;

  // Next count: clear wins, otherwise advance while enabled until the limit is reached.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != Limit)) begin
      count_d = count_q + CntW'(1);
    end
  end

  assign expired_o = WatchdogOn && enable_i && !clear_i &&
                     (count_q != Limit) && (count_d == Limit);

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/axi_lite_initiator.sv
// Native valid/ready memory bus to AXI4-Lite master bridge.
// Each native request becomes exactly one AXI read or write transaction.
// A watchdog forces an error completion on a transaction that hangs.
module axi_lite_initiator
  import axi_lite_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = DEFAULT_ERR_RDATA
) (
  input  logic        CLK,
  input  logic        RSTb,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        bus_error,
  output logic        mem_axi_awvalid,
  input  logic        mem_axi_awready,
  output logic [31:0] mem_axi_awaddr,
  output logic [2:0]  mem_axi_awprot,
  output logic        mem_axi_wvalid,
  input  logic        mem_axi_wready,
  output logic [31:0] mem_axi_wdata,
  output logic [3:0]  mem_axi_wstrb,
  input  logic        mem_axi_bvalid,
  output logic        mem_axi_bready,
  output logic        mem_axi_arvalid,
  input  logic        mem_axi_arready,
  output logic [31:0] mem_axi_araddr,
  output logic [2:0]  mem_axi_arprot,
  input  logic        mem_axi_rvalid,
  output logic        mem_axi_rready,
  input  logic [31:0] mem_axi_rdata
);

  state_e      state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [2:0]  prot_q;
  logic        awvalid_q;
  logic        wvalid_q;
  logic        arvalid_q;
  logic        bready_q;
  logic        rready_q;
  logic        mem_ready_q;
  logic        bus_error_q;
  logic [31:0] rdata_q;
  logic        aw_done_q;
  logic        w_done_q;
  logic        aw_done_d;
  logic        w_done_d;

  logic        busy;
  logic        resp_now;
  logic        timer_expired;

  assign busy = (state_q == ST_RD_ADDR) || (state_q == ST_RD_DATA) ||
                (state_q == ST_WR_ADDR_DATA) || (state_q == ST_WR_RESP);

  // A response arriving on the same edge as the watchdog takes priority.
  assign resp_now = ((state_q == ST_RD_DATA) && mem_axi_rvalid) ||
                    ((state_q == ST_WR_RESP) && mem_axi_bvalid);

  // Write address and write data handshakes complete independently.
  always_comb begin
    aw_done_d = aw_done_q | (awvalid_q & mem_axi_awready);
    w_done_d  = w_done_q  | (wvalid_q  & mem_axi_wready);
  end

  bus_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i    (CLK),
    .rst_ni   (RSTb),
    .clear_i  (state_q == ST_IDLE),
    .enable_i (busy),
    .expired_o(timer_expired)
  );

  // Transaction sequencer with all bus-facing outputs held in registers.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      prot_q      <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      mem_ready_q <= 1'b0;
      bus_error_q <= 1'b0;
      rdata_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
    end else begin
      mem_ready_q <= 1'b0;
      bus_error_q <= 1'b0;
      if (busy && timer_expired && !resp_now) begin
        awvalid_q   <= 1'b0;
        wvalid_q    <= 1'b0;
        arvalid_q   <= 1'b0;
        bready_q    <= 1'b0;
        rready_q    <= 1'b0;
        mem_ready_q <= 1'b1;
        bus_error_q <= 1'b1;
        if (wstrb_q == 4'b0000) begin
          rdata_q <= ERR_RDATA;
        end
        state_q <= ST_DONE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (mem_valid) begin
              addr_q    <= mem_addr;
              wdata_q   <= mem_wdata;
              wstrb_q   <= mem_wstrb;
              prot_q    <= prot_for(mem_instr);
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              if (mem_wstrb == 4'b0000) begin
                arvalid_q <= 1'b1;
                state_q   <= ST_RD_ADDR;
              end else begin
                awvalid_q <= 1'b1;
                wvalid_q  <= 1'b1;
                state_q   <= ST_WR_ADDR_DATA;
              end
            end
          end
          ST_RD_ADDR: begin
            if (mem_axi_arready) begin
              arvalid_q <= 1'b0;
              rready_q  <= 1'b1;
              state_q   <= ST_RD_DATA;
            end
          end
          ST_RD_DATA: begin
            if (mem_axi_rvalid) begin
              rdata_q     <= mem_axi_rdata;
              rready_q    <= 1'b0;
              mem_ready_q <= 1'b1;
              state_q     <= ST_DONE;
            end
          end
          ST_WR_ADDR_DATA: begin
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            if (aw_done_d) begin
              awvalid_q <= 1'b0;
            end
            if (w_done_d) begin
              wvalid_q <= 1'b0;
            end
            if (aw_done_d && w_done_d) begin
              bready_q <= 1'b1;
              state_q  <= ST_WR_RESP;
            end
          end
          ST_WR_RESP: begin
            if (mem_axi_bvalid) begin
              bready_q    <= 1'b0;
              mem_ready_q <= 1'b1;
              state_q     <= ST_DONE;
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign mem_ready       = mem_ready_q;
  assign mem_rdata       = rdata_q;
  assign bus_error       = bus_error_q;
  assign mem_axi_awvalid = awvalid_q;
  assign mem_axi_awaddr  = addr_q;
  assign mem_axi_awprot  = prot_q;
  assign mem_axi_wvalid  = wvalid_q;
  assign mem_axi_wdata   = wdata_q;
  assign mem_axi_wstrb   = wstrb_q;
  assign mem_axi_bready  = bready_q;
  assign mem_axi_arvalid = arvalid_q;
  assign mem_axi_araddr  = addr_q;
  assign mem_axi_arprot  = prot_q;
  assign mem_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_initiator.sv
// Self-checking bench for axi_lite_initiator.
// A transaction-level reference model runs alongside the DUT and is compared on every falling edge.
module tb_axi_lite_initiator;

  localparam int unsigned TO   = 16;
  localparam logic [31:0] ERRV = 32'hdeadbeef;

  logic        CLK = 1'b0;
  logic        RSTb = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_instr = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        bus_error;
  logic        awvalid, awready = 1'b0;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid, wready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid = 1'b0, bready;
  logic        arvalid, arready = 1'b0;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid = 1'b0, rready;
  logic [31:0] rdata = '0;

  axi_lite_initiator #(
    .TIMEOUT_CYCLES(TO),
    .ERR_RDATA     (ERRV)
  ) dut (
    .CLK            (CLK),
    .RSTb           (RSTb),
    .mem_valid      (mem_valid),
    .mem_instr      (mem_instr),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wstrb      (mem_wstrb),
    .mem_ready      (mem_ready),
    .mem_rdata      (mem_rdata),
    .bus_error      (bus_error),
    .mem_axi_awvalid(awvalid),
    .mem_axi_awready(awready),
    .mem_axi_awaddr (awaddr),
    .mem_axi_awprot (awprot),
    .mem_axi_wvalid (wvalid),
    .mem_axi_wready (wready),
    .mem_axi_wdata  (wdata),
    .mem_axi_wstrb  (wstrb),
    .mem_axi_bvalid (bvalid),
    .mem_axi_bready (bready),
    .mem_axi_arvalid(arvalid),
    .mem_axi_arready(arready),
    .mem_axi_araddr (araddr),
    .mem_axi_arprot (arprot),
    .mem_axi_rvalid (rvalid),
    .mem_axi_rready (rready),
    .mem_axi_rdata  (rdata)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;
  bit checking = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference model state: one outstanding request, described by which handshakes are still owed.
  bit          mBusy, mCooldown, mIsRead;
  int          mAge;
  logic [31:0] mAddr, mWdata;
  logic [3:0]  mWstrb;
  logic [2:0]  mProt;
  logic        expArvalid, expAwvalid, expWvalid, expRready, expBready;
  logic        expMemReady, expBusErr;
  logic [31:0] expRdata;

  // Advance the reference model on each rising edge using the inputs the DUT sees there.
  always @(posedge CLK) begin : refModel
    bit respSeen;
    if (!RSTb) begin
      mBusy = 0; mCooldown = 0; mIsRead = 0; mAge = 0;
      mAddr = '0; mWdata = '0; mWstrb = '0; mProt = '0;
      expArvalid = 0; expAwvalid = 0; expWvalid = 0; expRready = 0; expBready = 0;
      expMemReady = 0; expBusErr = 0; expRdata = '0;
    end else begin
      expMemReady = 0;
      expBusErr = 0;
      if (mCooldown) begin
        mCooldown = 0;
      end else if (!mBusy) begin
        if (mem_valid) begin
          mBusy = 1; mAge = 0;
          mAddr = mem_addr; mWdata = mem_wdata; mWstrb = mem_wstrb;
          mProt = mem_instr ? 3'b100 : 3'b000;
          mIsRead = (mem_wstrb == 4'b0000);
          if (mIsRead) expArvalid = 1;
          else begin expAwvalid = 1; expWvalid = 1; end
        end
      end else begin
        mAge++;
        respSeen = (expRready && rvalid) || (expBready && bvalid);
        if (respSeen) begin
          if (mIsRead) expRdata = rdata;
          expRready = 0; expBready = 0; expMemReady = 1;
          mBusy = 0; mCooldown = 1;
        end else if (mAge == int'(TO)) begin
          expArvalid = 0; expAwvalid = 0; expWvalid = 0; expRready = 0; expBready = 0;
          expMemReady = 1; expBusErr = 1;
          if (mIsRead) expRdata = ERRV;
          mBusy = 0; mCooldown = 1;
        end else begin
          if (expArvalid && arready) begin expArvalid = 0; expRready = 1; end
          if (expAwvalid && awready) expAwvalid = 0;
          if (expWvalid && wready) expWvalid = 0;
          if (!mIsRead && !expAwvalid && !expWvalid && !expBready) expBready = 1;
        end
      end
    end
  end

  // Compare every DUT output against the model mid-cycle.
  always @(negedge CLK) begin
    if (checking) begin
      checkOutput("mem_ready", 32'(mem_ready), 32'(expMemReady));
      checkOutput("bus_error", 32'(bus_error), 32'(expBusErr));
      checkOutput("arvalid", 32'(arvalid), 32'(expArvalid));
      checkOutput("awvalid", 32'(awvalid), 32'(expAwvalid));
      checkOutput("wvalid", 32'(wvalid), 32'(expWvalid));
      checkOutput("rready", 32'(rready), 32'(expRready));
      checkOutput("bready", 32'(bready), 32'(expBready));
      if (expMemReady && mIsRead) checkOutput("mem_rdata", mem_rdata, expRdata);
      if (expArvalid) begin
        checkOutput("araddr", araddr, mAddr);
        checkOutput("arprot", 32'(arprot), 32'(mProt));
      end
      if (expAwvalid) begin
        checkOutput("awaddr", awaddr, mAddr);
        checkOutput("awprot", 32'(awprot), 32'(mProt));
      end
      if (expWvalid) begin
        checkOutput("wdata", wdata, mWdata);
        checkOutput("wstrb", 32'(wstrb), 32'(mWstrb));
      end
    end
  end

  task automatic quiet(input int n);
    mem_valid = 0; mem_instr = 0; mem_wstrb = 0;
    arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // One cycle of random requester and responder activity.
  task automatic applyStimulus(input bit hang);
    mem_valid = ($urandom_range(0, 9) < 4);
    mem_instr = 1'($urandom_range(0, 1));
    mem_addr  = $urandom & 32'hffff_fffc;
    mem_wdata = $urandom;
    mem_wstrb = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
    arready   = 1'($urandom_range(0, 1));
    awready   = 1'($urandom_range(0, 1));
    wready    = 1'($urandom_range(0, 1));
    rvalid    = !hang && ($urandom_range(0, 9) < 3);
    bvalid    = !hang && ($urandom_range(0, 9) < 3);
    rdata     = $urandom;
    RSTb      = ($urandom_range(0, 299) != 0);
  endtask

  initial begin
    bit hang;
    RSTb = 0;
    tick();
    checking = 1;
    tick();
    checkOutput("rst_mem_ready", 32'(mem_ready), 32'd0);
    checkOutput("rst_bus_error", 32'(bus_error), 32'd0);
    checkOutput("rst_arvalid", 32'(arvalid), 32'd0);
    checkOutput("rst_awvalid", 32'(awvalid), 32'd0);
    checkOutput("rst_wvalid", 32'(wvalid), 32'd0);
    checkOutput("rst_rready", 32'(rready), 32'd0);
    checkOutput("rst_bready", 32'(bready), 32'd0);
    checkOutput("rst_mem_rdata", mem_rdata, 32'd0);
    checkOutput("rst_araddr", araddr, 32'd0);
    checkOutput("rst_wdata", wdata, 32'd0);
    RSTb = 1;
    quiet(2);

    // Read with two address wait cycles and a delayed single-cycle rvalid.
    mem_valid = 1; mem_addr = 32'h0000_0010; mem_wstrb = 0; mem_instr = 0;
    tick();
    mem_valid = 0; mem_addr = 32'hffff_0000;
    checkOutput("t1_arvalid_a", 32'(arvalid), 32'd1);
    checkOutput("t1_araddr", araddr, 32'h0000_0010);
    checkOutput("t1_arprot", 32'(arprot), 32'd0);
    tick();
    checkOutput("t1_arvalid_b", 32'(arvalid), 32'd1);
    tick();
    checkOutput("t1_arvalid_c", 32'(arvalid), 32'd1);
    arready = 1;
    tick();
    arready = 0;
    checkOutput("t1_arvalid_drop", 32'(arvalid), 32'd0);
    checkOutput("t1_rready", 32'(rready), 32'd1);
    tick();
    tick();
    rvalid = 1; rdata = 32'h1234_5678;
    tick();
    rvalid = 0; rdata = 32'h0;
    checkOutput("t1_mem_ready", 32'(mem_ready), 32'd1);
    checkOutput("t1_mem_rdata", mem_rdata, 32'h1234_5678);
    checkOutput("t1_bus_error", 32'(bus_error), 32'd0);
    tick();
    checkOutput("t1_single_pulse", 32'(mem_ready), 32'd0);
    quiet(2);

    // Instruction fetch against a zero-wait responder.
    mem_valid = 1; mem_instr = 1; mem_addr = 32'h0000_0200; mem_wstrb = 0;
    arready = 1; rvalid = 1; rdata = 32'ha5a5_0001;
    tick();
    mem_valid = 0; mem_instr = 0;
    checkOutput("t2_arprot", 32'(arprot), 32'd4);
    checkOutput("t2_ready_early1", 32'(mem_ready), 32'd0);
    tick();
    checkOutput("t2_ready_early2", 32'(mem_ready), 32'd0);
    tick();
    checkOutput("t2_mem_ready", 32'(mem_ready), 32'd1);
    checkOutput("t2_mem_rdata", mem_rdata, 32'ha5a5_0001);
    quiet(2);

    // Write where W completes three cycles before AW.
    mem_valid = 1; mem_addr = 32'h1000_0004; mem_wdata = 32'hcafe_f00d; mem_wstrb = 4'hf;
    tick();
    mem_valid = 0; mem_wdata = 32'h0;
    checkOutput("t3_awaddr", awaddr, 32'h1000_0004);
    checkOutput("t3_wdata", wdata, 32'hcafe_f00d);
    checkOutput("t3_wstrb", 32'(wstrb), 32'hf);
    wready = 1;
    tick();
    wready = 0;
    checkOutput("t3_wvalid_drop", 32'(wvalid), 32'd0);
    checkOutput("t3_awvalid_held", 32'(awvalid), 32'd1);
    tick();
    tick();
    checkOutput("t3_bready_wait", 32'(bready), 32'd0);
    checkOutput("t3_wvalid_stays", 32'(wvalid), 32'd0);
    awready = 1;
    tick();
    awready = 0;
    checkOutput("t3_awvalid_drop", 32'(awvalid), 32'd0);
    checkOutput("t3_bready", 32'(bready), 32'd1);
    bvalid = 1;
    tick();
    bvalid = 0;
    checkOutput("t3_mem_ready", 32'(mem_ready), 32'd1);
    checkOutput("t3_bready_drop", 32'(bready), 32'd0);
    quiet(2);

    // Simultaneous AW/W, then a read issued from a mem_valid that stays high.
    mem_valid = 1; mem_addr = 32'h3000_0008; mem_wdata = 32'h1111_2222; mem_wstrb = 4'b0011;
    awready = 1; wready = 1;
    tick();
    mem_wstrb = 0; mem_addr = 32'h4000_0000;
    checkOutput("t4_wstrb", 32'(wstrb), 32'h3);
    tick();
    checkOutput("t4_aw_done", 32'(awvalid), 32'd0);
    checkOutput("t4_w_done", 32'(wvalid), 32'd0);
    checkOutput("t4_bready", 32'(bready), 32'd1);
    bvalid = 1;
    tick();
    bvalid = 0;
    checkOutput("t4_mem_ready", 32'(mem_ready), 32'd1);
    checkOutput("t4_no_reassert", 32'(awvalid | wvalid), 32'd0);
    tick();
    checkOutput("t4_gap_arvalid", 32'(arvalid), 32'd0);
    tick();
    checkOutput("t4_b2b_arvalid", 32'(arvalid), 32'd1);
    checkOutput("t4_b2b_araddr", araddr, 32'h4000_0000);
    mem_valid = 0; awready = 0; wready = 0; arready = 1;
    tick();
    arready = 0; rvalid = 1; rdata = 32'h0bad_f00d;
    tick();
    rvalid = 0;
    checkOutput("t4_rd_ready", 32'(mem_ready), 32'd1);
    checkOutput("t4_rd_rdata", mem_rdata, 32'h0bad_f00d);
    quiet(2);

    // Read that is never answered trips the watchdog.
    mem_valid = 1; mem_addr = 32'h5000_0000; mem_wstrb = 0;
    tick();
    mem_valid = 0;
    for (int i = 1; i <= 15; i++) begin
      arready = (i == 1);
      tick();
      checkOutput("t5_no_early_ready", 32'(mem_ready), 32'd0);
    end
    arready = 0;
    tick();
    checkOutput("t5_timeout_ready", 32'(mem_ready), 32'd1);
    checkOutput("t5_timeout_error", 32'(bus_error), 32'd1);
    checkOutput("t5_timeout_rdata", mem_rdata, ERRV);
    checkOutput("t5_rready_clear", 32'(rready), 32'd0);
    tick();
    tick();
    rvalid = 1; rdata = 32'h9999_9999;
    tick();
    rvalid = 0;
    checkOutput("t5_late_ignored", 32'(mem_ready), 32'd0);
    checkOutput("t5_late_rready", 32'(rready), 32'd0);
    quiet(2);

    // Reset while waiting for read data, then a clean read.
    mem_valid = 1; mem_addr = 32'h0000_0060; mem_wstrb = 0;
    tick();
    mem_valid = 0; arready = 1;
    tick();
    arready = 0;
    checkOutput("t6_rready_before", 32'(rready), 32'd1);
    RSTb = 0; rvalid = 1; rdata = 32'h5555_aaaa;
    tick();
    RSTb = 1; rvalid = 0;
    checkOutput("t6_rst_rready", 32'(rready), 32'd0);
    checkOutput("t6_rst_arvalid", 32'(arvalid), 32'd0);
    checkOutput("t6_rst_mem_ready", 32'(mem_ready), 32'd0);
    tick();
    checkOutput("t6_no_ready_after", 32'(mem_ready), 32'd0);
    mem_valid = 1; mem_addr = 32'h0000_0064; arready = 1; rvalid = 1; rdata = 32'h7777_8888;
    tick();
    mem_valid = 0;
    tick();
    tick();
    checkOutput("t6_after_ready", 32'(mem_ready), 32'd1);
    checkOutput("t6_after_rdata", mem_rdata, 32'h7777_8888);
    quiet(2);

    // Randomized traffic with occasional silent-responder windows and resets.
    hang = 0;
    for (int c = 0; c < 3000; c++) begin
      if ((c % 40) == 0) hang = ($urandom_range(0, 3) == 0);
      applyStimulus(hang);
      tick();
    end
    RSTb = 1;
    quiet(30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
